// File: rtl/rv_mc_pkg.sv
// rv_mc_pkg: shared definitions for the rv_mc multicycle RV32I-subset core.
//   - opcode constants for the supported instruction classes
//   - controller FSM state enum
//   - ALU operation, immediate-format and datapath mux-select enums
//   - ctrl_t: control bundle driven by the controller into the datapath
//   - imm_ext: immediate extraction / sign extension for every format
package rv_mc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BEQ, S_JAL
  } state_e;

  typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT} alu_ctrl_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_J, IMM_U} imm_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_TARGET, PC_ALUOUT} pc_sel_e;
  typedef enum logic [1:0] {SRCA_REG, SRCA_OLDPC, SRCA_ZERO} srca_e;
  typedef enum logic [1:0] {SRCB_REG, SRCB_IMM, SRCB_FOUR} srcb_e;
  typedef enum logic [1:0] {RES_ALUOUT, RES_DATA, RES_ALU} res_e;
  typedef enum logic {ADR_PC, ADR_ALUOUT} adr_e;
  typedef enum logic {AO_ALU, AO_TARGET} ao_e;

  typedef struct packed {
    logic      ir_we;      // load instr and oldpc from memory / pc
    logic      pc_we;
    pc_sel_e   pc_sel;
    logic      ab_we;      // latch register-file read ports into A/B
    logic      data_we;
    logic      aluout_we;
    ao_e       ao_sel;
    srca_e     srca;
    srcb_e     srcb;
    imm_e      imm_sel;
    alu_ctrl_e alu_ctrl;
    logic      reg_we;
    res_e      res_sel;
    adr_e      adr_sel;
    logic      mem_we;
  } ctrl_t;

  // Branch and jump offsets carry an implicit zero LSB.
  function automatic logic [31:0] imm_ext(input logic [31:0] i, input imm_e sel);
    case (sel)
      IMM_S:   return {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_J:   return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_U:   return {i[31:12], 12'b0};
      default: return {{20{i[31]}}, i[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/rv_mc_if.sv
// rv_mc_if: unified memory bus between the datapath (master) and the word RAM (slave).
//   adr : byte address (word index = adr[31:2] mod depth)
//   wd  : write data (full word)
//   we  : write enable, sampled on the rising clock edge
//   rd  : asynchronous read data
interface rv_mc_if;
  logic [31:0] adr;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd;

  modport master (output adr, output wd, output we, input rd);
  modport slave  (input adr, input wd, input we, output rd);
endinterface

// File: rtl/rv_mc_ctrl.sv
// rv_mc_ctrl: multicycle controller FSM plus ALU decoder.
// Ports:
//   clk, rst  : clock / synchronous active-high reset (FSM returns to FETCH)
//   op        : instruction opcode field
//   funct3    : instruction funct3 field
//   funct7b5  : instruction bit 30 (sub select for R-type only)
//   zero      : ALU result equals zero (branch compare)
//   ctl       : control bundle to the datapath
// Optional feature: macro RV_MC_LUI_EN adds LUI via the EXECUTEI path.
module rv_mc_ctrl
  import rv_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output ctrl_t      ctl
);

  state_e state_q, state_d;

  // I-type immediates may have bit 30 set (e.g. negative addi), so only
  // R-type honours funct7[5] as the subtract select.
  function automatic alu_ctrl_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                           input logic is_r);
    case (f3)
      3'b000:  return (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  return ALU_SLT;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      S_FETCH: begin
        ctl.adr_sel = ADR_PC;
        ctl.ir_we   = 1'b1;
        ctl.pc_we   = 1'b1;
        ctl.pc_sel  = PC_PLUS4;
        state_d     = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here so BEQ only needs the compare.
        ctl.ab_we     = 1'b1;
        ctl.aluout_we = 1'b1;
        ctl.ao_sel    = AO_TARGET;
        ctl.imm_sel   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECUTER;
          OP_ITYPE:          state_d = S_EXECUTEI;
          OP_BRANCH:         state_d = S_BEQ;
          OP_JAL:            state_d = S_JAL;
`ifdef RV_MC_LUI_EN
          OP_LUI:            state_d = S_EXECUTEI;
`endif
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ctl.aluout_we = 1'b1;
        ctl.ao_sel    = AO_ALU;
        ctl.srca      = SRCA_REG;
        ctl.srcb      = SRCB_IMM;
        ctl.imm_sel   = (op == OP_STORE) ? IMM_S : IMM_I;
        ctl.alu_ctrl  = ALU_ADD;
        state_d       = (op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        ctl.adr_sel = ADR_ALUOUT;
        ctl.data_we = 1'b1;
        state_d     = S_MEMWB;
      end
      S_MEMWB: begin
        ctl.reg_we  = 1'b1;
        ctl.res_sel = RES_DATA;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        ctl.adr_sel = ADR_ALUOUT;
        ctl.mem_we  = 1'b1;
        state_d     = S_FETCH;
      end
      S_EXECUTER: begin
        ctl.aluout_we = 1'b1;
        ctl.ao_sel    = AO_ALU;
        ctl.srca      = SRCA_REG;
        ctl.srcb      = SRCB_REG;
        ctl.alu_ctrl  = alu_decode(funct3, funct7b5, 1'b1);
        state_d       = S_ALUWB;
      end
      S_EXECUTEI: begin
        ctl.aluout_we = 1'b1;
        ctl.ao_sel    = AO_ALU;
        ctl.srca      = SRCA_REG;
        ctl.srcb      = SRCB_IMM;
        ctl.imm_sel   = IMM_I;
        ctl.alu_ctrl  = alu_decode(funct3, funct7b5, 1'b0);
`ifdef RV_MC_LUI_EN
        // LUI: 0 + (instr[31:12] << 12)
        if (op == OP_LUI) begin
          ctl.srca     = SRCA_ZERO;
          ctl.imm_sel  = IMM_U;
          ctl.alu_ctrl = ALU_ADD;
        end
`endif
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        ctl.reg_we  = 1'b1;
        ctl.res_sel = RES_ALUOUT;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        ctl.srca     = SRCA_REG;
        ctl.srcb     = SRCB_REG;
        ctl.alu_ctrl = ALU_SUB;
        ctl.pc_we    = zero;
        ctl.pc_sel   = PC_ALUOUT;
        state_d      = S_FETCH;
      end
      S_JAL: begin
        // Jump target via the target adder; return address via the ALU.
        ctl.pc_we     = 1'b1;
        ctl.pc_sel    = PC_TARGET;
        ctl.imm_sel   = IMM_J;
        ctl.aluout_we = 1'b1;
        ctl.ao_sel    = AO_ALU;
        ctl.srca      = SRCA_OLDPC;
        ctl.srcb      = SRCB_FOUR;
        ctl.alu_ctrl  = ALU_ADD;
        state_d       = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: rtl/rv_mc.sv
// rv_mc: multicycle RV32I-subset CPU (lw sw add sub and or slt addi andi ori
// slti beq jal) with one unified instruction/data word RAM.
// Ports: clk (rising-edge clock), rst (synchronous, active-high reset).
// Parameters: MEM_WORDS (RAM depth in words), RESET_PC (pc after reset).
// Hierarchy: CTRL (rv_mc_ctrl), DP (rv_mc_dp, with DP.rf register file),
//            MEM (rv_mc_mem, array RAM).
// Optional feature: macro RV_MC_LUI_EN enables LUI; otherwise LUI is a NOP.

// Register file: 2 async read ports, 1 sync write port; x0 hard-wired to zero.
module rv_mc_rf (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] Register [0:31];

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : Register[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : Register[ra2];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) Register[i] <= 32'd0;
    end else if (we && (wa != 5'd0)) begin
      Register[wa] <= wd;
    end
  end
endmodule

// Datapath: architectural and non-architectural registers, ALU, muxes.
module rv_mc_dp
  import rv_mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  ctrl_t        ctl,
  rv_mc_if.master      bus,
  output logic [6:0]   op,
  output logic [2:0]   funct3,
  output logic         funct7b5,
  output logic         zero
);
  logic [31:0] pc, oldpc, instr, data, A, B, aluout;
  logic [31:0] pc_d, oldpc_d, instr_d, data_d, A_d, B_d, aluout_d;
  logic [31:0] imm, target, src_a, src_b, alu_y, result, rd1, rd2;

  function automatic logic [31:0] alu_op(input logic [31:0] a, input logic [31:0] b,
                                         input alu_ctrl_e c);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (c)
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_SLT: return (sa < sb) ? 32'd1 : 32'd0;
      default: return a + b;
    endcase
  endfunction

  assign op       = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7b5 = instr[30];

  assign imm    = imm_ext(instr, ctl.imm_sel);
  assign target = oldpc + imm;

  always_comb begin
    case (ctl.srca)
      SRCA_OLDPC: src_a = oldpc;
      SRCA_ZERO:  src_a = 32'd0;
      default:    src_a = A;
    endcase
    case (ctl.srcb)
      SRCB_IMM:  src_b = imm;
      SRCB_FOUR: src_b = 32'd4;
      default:   src_b = B;
    endcase
  end

  assign alu_y = alu_op(src_a, src_b, ctl.alu_ctrl);
  assign zero  = (alu_y == 32'd0);

  always_comb begin
    case (ctl.res_sel)
      RES_DATA: result = data;
      RES_ALU:  result = alu_y;
      default:  result = aluout;
    endcase
  end

  assign bus.adr = (ctl.adr_sel == ADR_ALUOUT) ? aluout : pc;
  assign bus.wd  = B;
  assign bus.we  = ctl.mem_we;

  always_comb begin
    pc_d     = pc;
    oldpc_d  = oldpc;
    instr_d  = instr;
    data_d   = data;
    A_d      = A;
    B_d      = B;
    aluout_d = aluout;
    if (ctl.ir_we) begin
      instr_d = bus.rd;
      oldpc_d = pc;
    end
    if (ctl.pc_we) begin
      case (ctl.pc_sel)
        PC_TARGET: pc_d = target;
        PC_ALUOUT: pc_d = aluout;
        default:   pc_d = pc + 32'd4;
      endcase
    end
    if (ctl.ab_we) begin
      A_d = rd1;
      B_d = rd2;
    end
    if (ctl.data_we)   data_d   = bus.rd;
    if (ctl.aluout_we) aluout_d = (ctl.ao_sel == AO_TARGET) ? target : alu_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      oldpc  <= 32'd0;
      instr  <= 32'd0;
      data   <= 32'd0;
      A      <= 32'd0;
      B      <= 32'd0;
      aluout <= 32'd0;
    end else begin
      pc     <= pc_d;
      oldpc  <= oldpc_d;
      instr  <= instr_d;
      data   <= data_d;
      A      <= A_d;
      B      <= B_d;
      aluout <= aluout_d;
    end
  end

  rv_mc_rf rf (
    .clk (clk),
    .rst (rst),
    .ra1 (instr[19:15]),
    .ra2 (instr[24:20]),
    .wa  (instr[11:7]),
    .we  (ctl.reg_we),
    .wd  (result),
    .rd1 (rd1),
    .rd2 (rd2)
  );
endmodule

// Unified word RAM: async read, sync full-word write; contents not reset.
module rv_mc_mem #(
  parameter int MEM_WORDS = 64
) (
  input  logic    clk,
  input  logic    rst,
  rv_mc_if.slave  bus
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] RAM [0:MEM_WORDS-1];
  logic [29:0] word_idx;
  logic [AW-1:0] idx;
  logic unused_bits;

  // Byte offset is ignored; the word index wraps modulo the depth.
  assign word_idx    = bus.adr[31:2] % 30'(MEM_WORDS);
  assign idx         = word_idx[AW-1:0];
  assign unused_bits = ^{bus.adr[1:0], word_idx[29:AW]};
  assign bus.rd      = RAM[idx];

  // A write coinciding with reset belongs to an aborted instruction.
  always_ff @(posedge clk) begin
    if (!rst && bus.we) RAM[idx] <= bus.wd;
  end
endmodule

module rv_mc
  import rv_mc_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input logic clk,
  input logic rst
);
  rv_mc_if mbus ();

  ctrl_t      ctl;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  rv_mc_ctrl CTRL (
    .clk      (clk),
    .rst      (rst),
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .zero     (zero),
    .ctl      (ctl)
  );

  rv_mc_dp #(.RESET_PC(RESET_PC)) DP (
    .clk      (clk),
    .rst      (rst),
    .ctl      (ctl),
    .bus      (mbus),
    .op       (op),
    .funct3   (funct3),
    .funct7b5 (funct7b5),
    .zero     (zero)
  );

  rv_mc_mem #(.MEM_WORDS(MEM_WORDS)) MEM (
    .clk (clk),
    .rst (rst),
    .bus (mbus)
  );
endmodule

// File: tb/tb_rv_mc.sv
// tb_rv_mc: directed program for rv_mc with hand-computed register, pc,
// memory and cycle-count expectations; a second phase aborts a store by reset.
module tb_rv_mc;
  import rv_mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc;

  always #5 clk = ~clk;

  rv_mc dut (.clk(clk), .rst(rst));

  // Observer copy of the internal memory bus.
  rv_mc_if mon ();
  assign mon.adr = dut.mbus.adr;
  assign mon.wd  = dut.mbus.wd;
  assign mon.we  = dut.mbus.we;
  assign mon.rd  = dut.mbus.rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: lets exactly n rising edges pass, returns at a negedge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] st(input state_e s);
    return 32'(s);
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) dut.MEM.RAM[i] = 32'h0;
    dut.MEM.RAM[0]  = 32'h00500093; // addi x1,x0,5
    dut.MEM.RAM[1]  = 32'h00300113; // addi x2,x0,3
    dut.MEM.RAM[2]  = 32'h002081B3; // add  x3,x1,x2
    dut.MEM.RAM[3]  = 32'h40208233; // sub  x4,x1,x2
    dut.MEM.RAM[4]  = 32'h001122B3; // slt  x5,x2,x1
    dut.MEM.RAM[5]  = 32'h00302023; // sw   x3,0(x0)
    dut.MEM.RAM[6]  = 32'h00002303; // lw   x6,0(x0)
    dut.MEM.RAM[7]  = 32'h00108463; // beq  x1,x1,+8
    dut.MEM.RAM[8]  = 32'h00100393; // addi x7,x0,1 (skipped)
    dut.MEM.RAM[9]  = 32'h00208463; // beq  x1,x2,+8 (not taken)
    dut.MEM.RAM[10] = 32'h0060F413; // andi x8,x1,6
    dut.MEM.RAM[11] = 32'h00816493; // ori  x9,x2,8
    dut.MEM.RAM[12] = 32'hFFD00593; // addi x11,x0,-3
    dut.MEM.RAM[13] = 32'h0015A513; // slti x10,x11,1
    dut.MEM.RAM[14] = 32'hFFFFFFFF; // unknown opcode
    dut.MEM.RAM[15] = 32'h12345637; // lui  x12,0x12345
    dut.MEM.RAM[16] = 32'h010000EF; // jal  x1,+16
    dut.MEM.RAM[17] = 32'h00100693; // addi x13,x0,1 (skipped)
    dut.MEM.RAM[18] = 32'h00100693;
    dut.MEM.RAM[19] = 32'h00100693;
    dut.MEM.RAM[20] = 32'h00700013; // addi x0,x0,7
    dut.MEM.RAM[21] = 32'h06102023; // sw   x1,0x60(x0)
    dut.MEM.RAM[22] = 32'h00000063; // beq  x0,x0,0 (spin)

    rst = 1'b1;
    step(2);
    chk("rst_pc", dut.DP.pc, 32'h0);
    chk("rst_state", st(dut.CTRL.state_q), st(S_FETCH));
    chk("rst_aluout", dut.DP.aluout, 32'h0);
    for (int i = 1; i < 32; i++)
      chk($sformatf("rst_x%0d", i), dut.DP.rf.Register[i], 32'h0);
    chk("rst_bus_adr", mon.adr, 32'h0);
    chk("rst_bus_rd", mon.rd, 32'h00500093);
    rst = 1'b0;

    step(8);
    chk("addi_x1", dut.DP.rf.Register[1], 32'd5);
    chk("addi_x2", dut.DP.rf.Register[2], 32'd3);
    chk("addi_pc", dut.DP.pc, 32'h8);

    step(3);
    chk("add_3cyc_x3", dut.DP.rf.Register[3], 32'd0);
    chk("add_3cyc_state", st(dut.CTRL.state_q), st(S_ALUWB));
    step(1);
    chk("add_x3", dut.DP.rf.Register[3], 32'd8);
    step(4);
    chk("sub_x4", dut.DP.rf.Register[4], 32'd2);
    step(4);
    chk("slt_x5", dut.DP.rf.Register[5], 32'd1);
    chk("slt_pc", dut.DP.pc, 32'h14);

    step(3);
    chk("sw_state", st(dut.CTRL.state_q), st(S_MEMWRITE));
    chk("sw_bus_we", 32'(mon.we), 32'd1);
    chk("sw_bus_wd", mon.wd, 32'd8);
    chk("sw_before", dut.MEM.RAM[0], 32'h00500093);
    step(1);
    chk("sw_ram0", dut.MEM.RAM[0], 32'h00000008);
    chk("sw_pc", dut.DP.pc, 32'h18);

    step(4);
    chk("lw_4cyc_x6", dut.DP.rf.Register[6], 32'd0);
    chk("lw_result", dut.DP.result, 32'd8);
    step(1);
    chk("lw_x6", dut.DP.rf.Register[6], 32'd8);
    chk("lw_pc", dut.DP.pc, 32'h1C);

    step(2);
    chk("beq_t_mid_pc", dut.DP.pc, 32'h20);
    step(1);
    chk("beq_t_pc", dut.DP.pc, 32'h24);
    chk("beq_t_state", st(dut.CTRL.state_q), st(S_FETCH));
    step(3);
    chk("beq_nt_pc", dut.DP.pc, 32'h28);
    chk("beq_skip_x7", dut.DP.rf.Register[7], 32'd0);

    step(4);
    chk("andi_x8", dut.DP.rf.Register[8], 32'd4);
    step(4);
    chk("ori_x9", dut.DP.rf.Register[9], 32'd11);
    step(4);
    chk("addi_neg_x11", dut.DP.rf.Register[11], 32'hFFFFFFFD);
    step(4);
    chk("slti_x10", dut.DP.rf.Register[10], 32'd1);

    step(2);
    chk("nop_pc", dut.DP.pc, 32'h3C);
    chk("nop_state", st(dut.CTRL.state_q), st(S_FETCH));
`ifdef RV_MC_LUI_EN
    step(4);
    chk("lui_x12", dut.DP.rf.Register[12], 32'h12345000);
`else
    step(2);
    chk("lui_nop_x12", dut.DP.rf.Register[12], 32'h0);
`endif
    chk("lui_pc", dut.DP.pc, 32'h40);

    step(3);
    chk("jal_pc", dut.DP.pc, 32'h50);
    chk("jal_aluout", dut.DP.aluout, 32'h44);
    step(1);
    chk("jal_x1", dut.DP.rf.Register[1], 32'h44);
    step(4);
    chk("x0_zero", dut.DP.rf.Register[0], 32'h0);
    chk("jal_skip_x13", dut.DP.rf.Register[13], 32'h0);
    step(4);
    chk("sw_ram24", dut.MEM.RAM[24], 32'h44);
    chk("end_pc", dut.DP.pc, 32'h58);
    step(3);
    chk("spin_pc", dut.DP.pc, 32'h58);

    // Reset lands on the MEMWRITE edge of a store: the write must not happen.
    rst = 1'b1;
    dut.MEM.RAM[0]  = 32'h00500093; // addi x1,x0,5
    dut.MEM.RAM[1]  = 32'h06102223; // sw   x1,0x64(x0)
    dut.MEM.RAM[25] = 32'hDEADBEEF;
    step(2);
    rst = 1'b0;
    cyc = 0;
    while (dut.CTRL.state_q !== S_MEMWRITE && cyc < 20) begin
      step(1);
      cyc++;
    end
    chk("abort_reach_memwrite", st(dut.CTRL.state_q), st(S_MEMWRITE));
    chk("abort_cycles", 32'(cyc), 32'd7);
    rst = 1'b1;
    step(1);
    chk("abort_ram25", dut.MEM.RAM[25], 32'hDEADBEEF);
    chk("abort_pc", dut.DP.pc, 32'h0);
    chk("abort_state", st(dut.CTRL.state_q), st(S_FETCH));
    chk("abort_x1", dut.DP.rf.Register[1], 32'h0);
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
